// File: rtl/ext_int_controller.sv
// ----------------------------------------------------------------------------
// ext_int_controller
//
// External interrupt controller in front of the core's EIC port. Rising edges
// on Src_Irq are latched into PENDING, masked by ENABLE, and the winning
// eligible source is offered to the core through a four-phase
// EIC_IntReq / EIC_IntId / EIC_IntAck handshake.
//
// Build option:
//   EIC_ROUND_ROBIN_EN  defined   -> round-robin arbitration starting after the
//                                    last acknowledged source
//                       undefined -> fixed priority, lowest index wins
//
// Ports:
//   Sys_Clock   in   system clock, rising edge
//   Sys_Reset   in   asynchronous active-low reset
//   Src_Irq     in   [NUM_SRC]  edge-triggered interrupt lines
//   Reg_WrEn    in   register write strobe
//   Reg_RdEn    in   register read strobe
//   Reg_Addr    in   [2]  0=ENABLE 1=PENDING(W1C) 2=STATUS 3=reserved
//   Reg_WrData  in   [32] write data
//   Reg_RdData  out  [32] registered read data, held until the next read
//   EIC_IntReq  out  interrupt request to the core
//   EIC_IntId   out  [ID_WIDTH] index of the requested source
//   EIC_IntAck  in   acknowledge from the core
//
// state | meaning
// IDLE  | no request outstanding, waiting for an eligible source
// REQ   | EIC_IntReq high, IntId frozen, waiting for EIC_IntAck
// GAP   | one forced low cycle on EIC_IntReq before the next request
// ----------------------------------------------------------------------------
module ext_int_controller #(
    parameter int NUM_SRC  = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic                Sys_Clock,
    input  logic                Sys_Reset,
    input  logic [NUM_SRC-1:0]  Src_Irq,
    input  logic                Reg_WrEn,
    input  logic                Reg_RdEn,
    input  logic [1:0]          Reg_Addr,
    input  logic [31:0]         Reg_WrData,
    output logic [31:0]         Reg_RdData,
    output logic                EIC_IntReq,
    output logic [ID_WIDTH-1:0] EIC_IntId,
    input  logic                EIC_IntAck
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [1:0] ADDR_ENABLE  = 2'd0;
    localparam logic [1:0] ADDR_PENDING = 2'd1;
    localparam logic [1:0] ADDR_STATUS  = 2'd2;

    state_t              state_q, state_d;
    logic [NUM_SRC-1:0]  src_q;
    logic [NUM_SRC-1:0]  enable_q, enable_d;
    logic [NUM_SRC-1:0]  pending_q, pending_d;
    logic                int_req_q, int_req_d;
    logic [ID_WIDTH-1:0] int_id_q, int_id_d;
    logic [31:0]         rd_data_q, rd_data_d;

    logic [NUM_SRC-1:0]  rise;
    logic [NUM_SRC-1:0]  eligible;
    logic [NUM_SRC-1:0]  ack_clr;
    logic [NUM_SRC-1:0]  w1c_clr;
    logic [ID_WIDTH-1:0] winner;

`ifdef EIC_ROUND_ROBIN_EN
    logic [ID_WIDTH-1:0] ptr_q, ptr_d;
`endif

    // Only the low NUM_SRC bits of write data reach any register.
    logic unused_wr_bits;
    assign unused_wr_bits = ^Reg_WrData[31:NUM_SRC];

    assign rise     = Src_Irq & ~src_q;
    assign eligible = pending_q & enable_q;

    // ------------------------------------------------------------------
    // Arbitration. Loops run from the least to the most preferred
    // candidate so the last match wins.
    // ------------------------------------------------------------------
    always_comb begin
        winner = '0;
`ifdef EIC_ROUND_ROBIN_EN
        for (int k = NUM_SRC; k >= 1; k--) begin
            int idx;
            idx = (int'(ptr_q) + k) % NUM_SRC;
            if (eligible[idx]) begin
                winner = ID_WIDTH'(idx);
            end
        end
`else
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (eligible[k]) begin
                winner = ID_WIDTH'(k);
            end
        end
`endif
    end

    // ------------------------------------------------------------------
    // Handshake FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        int_req_d = int_req_q;
        int_id_d  = int_id_q;
        ack_clr   = '0;
`ifdef EIC_ROUND_ROBIN_EN
        ptr_d     = ptr_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (eligible != '0) begin
                    int_req_d = 1'b1;
                    int_id_d  = winner;
                    state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                // The request is never withdrawn; only the ack ends it.
                if (EIC_IntAck) begin
                    ack_clr[int_id_q] = 1'b1;
                    int_req_d         = 1'b0;
                    state_d           = ST_GAP;
`ifdef EIC_ROUND_ROBIN_EN
                    ptr_d             = int_id_q;
`endif
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                int_req_d = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Register file. New edges are OR-ed in last so a set always beats a
    // same-cycle W1C or ack clear.
    // ------------------------------------------------------------------
    always_comb begin
        enable_d = enable_q;
        w1c_clr  = '0;
        if (Reg_WrEn) begin
            if (Reg_Addr == ADDR_ENABLE) begin
                enable_d = Reg_WrData[NUM_SRC-1:0];
            end
            if (Reg_Addr == ADDR_PENDING) begin
                w1c_clr = Reg_WrData[NUM_SRC-1:0];
            end
        end
        pending_d = (pending_q & ~w1c_clr & ~ack_clr) | rise;
    end

    // Read data reflects register contents before any same-cycle write.
    always_comb begin
        rd_data_d = rd_data_q;
        if (Reg_RdEn) begin
            rd_data_d = '0;
            unique case (Reg_Addr)
                ADDR_ENABLE:  rd_data_d[NUM_SRC-1:0] = enable_q;
                ADDR_PENDING: rd_data_d[NUM_SRC-1:0] = pending_q;
                ADDR_STATUS: begin
                    rd_data_d[0]             = (state_q != ST_IDLE);
                    rd_data_d[8 +: ID_WIDTH] = int_id_q;
                end
                default: rd_data_d = '0;
            endcase
        end
    end

    always_ff @(posedge Sys_Clock or negedge Sys_Reset) begin
        if (!Sys_Reset) begin
            state_q   <= ST_IDLE;
            src_q     <= '0;
            enable_q  <= '0;
            pending_q <= '0;
            int_req_q <= 1'b0;
            int_id_q  <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            src_q     <= Src_Irq;
            enable_q  <= enable_d;
            pending_q <= pending_d;
            int_req_q <= int_req_d;
            int_id_q  <= int_id_d;
            rd_data_q <= rd_data_d;
        end
    end

`ifdef EIC_ROUND_ROBIN_EN
    // Reset to the top index so the first search starts at source 0.
    always_ff @(posedge Sys_Clock or negedge Sys_Reset) begin
        if (!Sys_Reset) begin
            ptr_q <= ID_WIDTH'(NUM_SRC - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    assign EIC_IntReq = int_req_q;
    assign EIC_IntId  = int_id_q;
    assign Reg_RdData = rd_data_q;

endmodule

// File: tb/tb_ext_int_controller.sv
module tb_ext_int_controller;

    localparam int N   = 4;
    localparam int IDW = 2;

    logic           Sys_Clock;
    logic           Sys_Reset;
    logic [N-1:0]   Src_Irq;
    logic           Reg_WrEn;
    logic           Reg_RdEn;
    logic [1:0]     Reg_Addr;
    logic [31:0]    Reg_WrData;
    logic [31:0]    Reg_RdData;
    logic           EIC_IntReq;
    logic [IDW-1:0] EIC_IntId;
    logic           EIC_IntAck;

    int checks = 0;
    int errors = 0;

    ext_int_controller #(.NUM_SRC(N), .ID_WIDTH(IDW)) dut (
        .Sys_Clock  (Sys_Clock),
        .Sys_Reset  (Sys_Reset),
        .Src_Irq    (Src_Irq),
        .Reg_WrEn   (Reg_WrEn),
        .Reg_RdEn   (Reg_RdEn),
        .Reg_Addr   (Reg_Addr),
        .Reg_WrData (Reg_WrData),
        .Reg_RdData (Reg_RdData),
        .EIC_IntReq (EIC_IntReq),
        .EIC_IntId  (EIC_IntId),
        .EIC_IntAck (EIC_IntAck)
    );

    initial begin
        Sys_Clock = 1'b0;
        forever #5 Sys_Clock = ~Sys_Clock;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: plain bit vectors, a phase number and a request
    // record, advanced once per clock from the inputs the DUT also sees.
    // ------------------------------------------------------------------
    bit [N-1:0] m_en, m_pend, m_prev;
    int         m_phase;   // 0 waiting, 1 requesting, 2 forced low cycle
    bit         m_req;
    int         m_id;
    int         m_ptr;
    bit [31:0]  m_rd;

    function automatic int pick(input bit [N-1:0] elig, input int ptr);
`ifdef EIC_ROUND_ROBIN_EN
        for (int o = 1; o <= N; o++) begin
            int i;
            i = (ptr + o) % N;
            if (elig[i]) return i;
        end
`else
        for (int i = 0; i < N; i++) begin
            if (elig[i]) return i;
        end
`endif
        return 0;
    endfunction

    initial begin
        bit [N-1:0] rise_v, elig_v, nxt_v;
        forever begin
            @(posedge Sys_Clock or negedge Sys_Reset);
            if (!Sys_Reset) begin
                m_en = '0; m_pend = '0; m_prev = '0;
                m_phase = 0; m_req = 1'b0; m_id = 0; m_ptr = N - 1; m_rd = '0;
            end else begin
                rise_v = Src_Irq & ~m_prev;
                m_prev = Src_Irq;
                if (Reg_RdEn) begin
                    case (Reg_Addr)
                        2'd0:    m_rd = 32'(m_en);
                        2'd1:    m_rd = 32'(m_pend);
                        2'd2:    m_rd = ((m_phase != 0) ? 32'd1 : 32'd0) + 32'(m_id * 256);
                        default: m_rd = 32'd0;
                    endcase
                end
                elig_v = m_pend & m_en;
                nxt_v  = m_pend;
                if (Reg_WrEn && Reg_Addr == 2'd1) nxt_v = nxt_v & ~Reg_WrData[N-1:0];
                if (Reg_WrEn && Reg_Addr == 2'd0) m_en = Reg_WrData[N-1:0];
                if (m_phase == 0) begin
                    if (elig_v != 0) begin
                        m_id = pick(elig_v, m_ptr);
                        m_req = 1'b1;
                        m_phase = 1;
                    end
                end else if (m_phase == 1) begin
                    if (EIC_IntAck) begin
                        nxt_v[m_id] = 1'b0;
                        m_ptr = m_id;
                        m_req = 1'b0;
                        m_phase = 2;
                    end
                end else begin
                    m_phase = 0;
                end
                m_pend = nxt_v | rise_v;
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge Sys_Clock);
            check("model_req", 32'(EIC_IntReq), 32'(m_req));
            check("model_id", 32'(EIC_IntId), 32'(m_id));
            check("model_rddata", Reg_RdData, m_rd);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: inputs change 2 time units after a rising edge.
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge Sys_Clock);
        #2;
    endtask

    task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
        Reg_WrEn = 1'b1; Reg_Addr = a; Reg_WrData = d;
        tick();
        Reg_WrEn = 1'b0;
    endtask

    task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
        Reg_RdEn = 1'b1; Reg_Addr = a;
        tick();
        Reg_RdEn = 1'b0;
        d = Reg_RdData;
    endtask

    task automatic pulse(input logic [N-1:0] s);
        Src_Irq = s;
        tick();
        Src_Irq = '0;
    endtask

    task automatic wait_req(input int budget, input string name);
        int n;
        n = 0;
        while (!EIC_IntReq && n < budget) begin
            tick();
            n++;
        end
        check(name, 32'(EIC_IntReq), 32'd1);
    endtask

    task automatic do_ack();
        EIC_IntAck = 1'b1;
        tick();
        EIC_IntAck = 1'b0;
        check("ack_drop", 32'(EIC_IntReq), 32'd0);
        tick();
        check("ack_gap", 32'(EIC_IntReq), 32'd0);
    endtask

    initial begin
        logic [31:0] d;
        int first_id, second_id;
        Sys_Reset = 1'b1;
        Src_Irq = '0; Reg_WrEn = 1'b0; Reg_RdEn = 1'b0; Reg_Addr = '0;
        Reg_WrData = '0; EIC_IntAck = 1'b0;
        #1 Sys_Reset = 1'b0;
        repeat (3) @(posedge Sys_Clock);
        #2 Sys_Reset = 1'b1;
        tick();

        reg_read(2'd0, d); check("init_enable", d, 32'h0);
        reg_read(2'd1, d); check("init_pending", d, 32'h0);
        reg_read(2'd2, d); check("init_status", d, 32'h0);

        // Basic request on source 2.
        reg_write(2'd0, 32'hF);
        pulse(4'b0100);
        check("basic_not_yet", 32'(EIC_IntReq), 32'd0);
        tick();
        check("basic_req", 32'(EIC_IntReq), 32'd1);
        check("basic_id", 32'(EIC_IntId), 32'd2);
        reg_read(2'd2, d); check("basic_status", d, 32'h201);
        EIC_IntAck = 1'b1;
        tick();
        EIC_IntAck = 1'b0;
        check("basic_drop", 32'(EIC_IntReq), 32'd0);
        reg_read(2'd1, d); check("basic_pending_clr", d, 32'h0);
        check("basic_gap", 32'(EIC_IntReq), 32'd0);

        // Arbitration after a prior ack of source 1.
        pulse(4'b0010);
        wait_req(5, "arb_pre_req");
        check("arb_pre_id", 32'(EIC_IntId), 32'd1);
        do_ack();
        pulse(4'b1010);
        wait_req(5, "arb_first_req");
`ifdef EIC_ROUND_ROBIN_EN
        first_id = 3; second_id = 1;
`else
        first_id = 1; second_id = 3;
`endif
        check("arb_first_id", 32'(EIC_IntId), 32'(first_id));
        do_ack();
        wait_req(5, "arb_second_req");
        check("arb_second_id", 32'(EIC_IntId), 32'(second_id));
        do_ack();

        // Delayed ack with a new edge arriving while the request is held.
        pulse(4'b0100);
        wait_req(5, "dly_req");
        for (int c = 0; c < 50; c++) begin
            Src_Irq = (c == 20) ? 4'b0001 : 4'b0000;
            tick();
            check("dly_req_hold", 32'(EIC_IntReq), 32'd1);
            check("dly_id_hold", 32'(EIC_IntId), 32'd2);
        end
        Src_Irq = '0;
        reg_read(2'd1, d); check("dly_pending", d, 32'h5);
        do_ack();
        wait_req(5, "dly_src0_req");
        check("dly_src0_id", 32'(EIC_IntId), 32'd0);
        do_ack();

        // Masking, late enable, W1C.
        reg_write(2'd0, 32'h0);
        pulse(4'b0010);
        tick(); tick();
        reg_read(2'd1, d); check("mask_pending", d, 32'h2);
        check("mask_noreq", 32'(EIC_IntReq), 32'd0);
        reg_write(2'd0, 32'h2);
        wait_req(2, "mask_en_req");
        check("mask_en_id", 32'(EIC_IntId), 32'd1);
        do_ack();
        reg_write(2'd0, 32'h0);
        pulse(4'b0010);
        tick();
        Src_Irq = 4'b0010;
        Reg_WrEn = 1'b1; Reg_Addr = 2'd1; Reg_WrData = 32'h2;
        tick();
        Reg_WrEn = 1'b0; Src_Irq = '0;
        reg_read(2'd1, d); check("w1c_collide", d, 32'h2);
        reg_write(2'd1, 32'hFFFF_FFFF);
        reg_read(2'd1, d); check("w1c_clear", d, 32'h0);

        // Reset in the middle of a handshake.
        reg_write(2'd0, 32'hF);
        pulse(4'b1000);
        wait_req(5, "rsths_req");
        Sys_Reset = 1'b0;
        #1;
        check("rsths_drop", 32'(EIC_IntReq), 32'd0);
        check("rsths_id", 32'(EIC_IntId), 32'd0);
        @(posedge Sys_Clock);
        #2 Sys_Reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("rsths_quiet", 32'(EIC_IntReq), 32'd0);
        end
        pulse(4'b1000);
        tick(); tick();
        check("rsths_masked", 32'(EIC_IntReq), 32'd0);
        reg_write(2'd0, 32'h8);
        wait_req(2, "rsths_rearm_req");
        check("rsths_rearm_id", 32'(EIC_IntId), 32'd3);
        do_ack();

        // Reset mid-simulation with non-zero outputs.
        reg_write(2'd0, 32'hF);
        pulse(4'b0001);
        reg_read(2'd0, d); check("rst_pre_rd", d, 32'hF);
        Sys_Reset = 1'b0;
        #1;
        check("rst_req", 32'(EIC_IntReq), 32'd0);
        check("rst_id", 32'(EIC_IntId), 32'd0);
        check("rst_rddata", Reg_RdData, 32'h0);
        @(posedge Sys_Clock);
        #2 Sys_Reset = 1'b1;
        reg_read(2'd0, d); check("rst_enable", d, 32'h0);
        reg_read(2'd1, d); check("rst_pending", d, 32'h0);

        // Randomised traffic, checked by the model process.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 2) == 0) Src_Irq = N'($urandom);
            EIC_IntAck = ($urandom_range(0, 2) == 0);
            Reg_RdEn   = ($urandom_range(0, 2) == 0);
            Reg_WrEn   = ($urandom_range(0, 3) == 0);
            Reg_Addr   = 2'($urandom);
            Reg_WrData = $urandom;
            if ($urandom_range(0, 499) == 0) begin
                Sys_Reset = 1'b0;
                tick();
                Sys_Reset = 1'b1;
            end
            tick();
        end
        Src_Irq = '0; EIC_IntAck = 1'b0; Reg_RdEn = 1'b0; Reg_WrEn = 1'b0;
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
